ssd_word_source: RTL

Upstream feeder for the 16-bit output register stage. Accepts a byte stream, packs byte pairs little-endian into 16-bit words, buffers them in an internal FIFO and, on request, releases fixed-length bursts framed by a lead/trail enable. `data_en_out` and `frame_en` drive the output stage's data-enable and output-enable inputs; `data_out` drives its data input.

---
 rtl/ssd_word_source.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ssd_word_source.sv
// rtl/ssd_word_source.sv - byte-to-word packer, word FIFO and framed burst source
module ssd_word_source #(
    parameter int DEPTH     = 16,
    parameter int BURST_LEN = 4
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     byte_en,
    input  logic [7:0]               byte_in,
    input  logic                     flush,
    input  logic                     burst_req,
    output logic                     data_en_out,
    output logic [15:0]              data_out,
    output logic                     frame_en,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_DATA, S_TRAIL} state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [LW-1:0]   r_beat;
    logic            r_pending;
    logic            w_pending_next;
    logic            w_start;

    logic            r_half;
    logic [7:0]      r_low;
    logic            w_half_next;
    logic [7:0]      w_low_next;
    logic            w_push;
    logic [15:0]     w_push_word;

    logic [15:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_count;
    logic            r_overflow;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;

    logic            w_frame_d;
    logic            w_den_d;
    logic            w_busy_d;

    // Packer: pair bytes little-endian; flush pads a lone byte with zero
    always_comb begin
        w_push      = 1'b0;
        w_push_word = 16'h0000;
        w_half_next = r_half;
        w_low_next  = r_low;
        if (byte_en) begin
            if (r_half) begin
                w_push      = 1'b1;
                w_push_word = {byte_in, r_low};
                w_half_next = 1'b0;
            end else if (flush) begin
                w_push      = 1'b1;
                w_push_word = {8'h00, byte_in};
            end else begin
                w_low_next  = byte_in;
                w_half_next = 1'b1;
            end
        end else if (flush && r_half) begin
            w_push      = 1'b1;
            w_push_word = {8'h00, r_low};
            w_half_next = 1'b0;
        end
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign w_full    = (r_count == LW'(DEPTH));
    assign w_pop     = (w_next_state == S_DATA);
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Request latch: only one outstanding request, extras are dropped
    assign w_start = (r_state == S_IDLE) && r_pending && (r_count >= LW'(BURST_LEN));
    always_comb begin
        w_pending_next = r_pending;
        if (w_start)
            w_pending_next = 1'b0;
        else if (burst_req && (r_state == S_IDLE))
            w_pending_next = 1'b1;
    end

    // FSM state register and beat counter
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_pending <= w_pending_next;
            r_beat    <= (r_state == S_DATA) ? r_beat + LW'(1) : '0;
        end
    end

    // FSM next-state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next_state = S_LEAD;
            S_LEAD:  w_next_state = S_DATA;
            S_DATA:  if (r_beat == LW'(BURST_LEN - 1)) w_next_state = S_TRAIL;
            S_TRAIL: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from the upcoming state so the registered copies line up with it
    always_comb begin
        w_frame_d = (w_next_state != S_IDLE);
        w_den_d   = (w_next_state == S_DATA);
        w_busy_d  = w_pending_next || (w_next_state != S_IDLE);
    end

    // Word storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr] <= w_push_word;
    end

    // Packer state, FIFO pointers/level, sticky overflow and registered outputs
    always_ff @(posedge clk) begin
        if (!nRST) begin
            r_half      <= 1'b0;
            r_low       <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            frame_en    <= 1'b0;
            data_en_out <= 1'b0;
            busy        <= 1'b0;
            data_out    <= 16'h0000;
        end else begin
            r_half      <= w_half_next;
            r_low       <= w_low_next;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                data_out <= r_mem[r_rd_ptr];
            end
            if (w_push_ok && !w_pop)
                r_count <= r_count + LW'(1);
            else if (!w_push_ok && w_pop)
                r_count <= r_count - LW'(1);
            if (w_push && !w_push_ok)
                r_overflow <= 1'b1;
            frame_en    <= w_frame_d;
            data_en_out <= w_den_d;
            busy        <= w_busy_d;
        end
    end

    assign fifo_level = r_count;
    assign overflow   = r_overflow;

endmodule
